// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd: M:SS BCD cook timer counting down once per second.
// Define DOOR_INTERLOCK_EN to add door_open, which pauses RUN and blocks start.
module countdown_timer_bcd #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_min,
    input  logic [3:0] load_sec_tens,
    input  logic [3:0] load_sec_ones,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
`ifdef DOOR_INTERLOCK_EN
    input  logic       door_open,
`endif
    output logic [3:0] min,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       load_err
);
    localparam int DW = $clog2(TICKS_PER_SEC);
    localparam logic [DW-1:0] DIV_MAX = DW'(TICKS_PER_SEC - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    min_q, min_d, tens_q, tens_d, ones_q, ones_d;
    logic          running_q, running_d, done_q, done_d, err_q, err_d;
    logic          door, in_run, nonzero, load_ok, tick, last_sec, stop_req, start_req;

`ifdef DOOR_INTERLOCK_EN
    assign door = door_open;
`else
    assign door = 1'b0;
`endif

    // An open door acts like stop only while running; elsewhere it just blocks start.
    assign in_run    = state_q == RUN;
    assign stop_req  = stop | (door & in_run);
    assign start_req = start & ~door;
    assign nonzero   = |{min_q, tens_q, ones_q};
    assign load_ok   = load_min <= 4'd9 && load_sec_tens <= 4'd5 && load_sec_ones <= 4'd9;
    assign tick      = div_q == DIV_MAX;
    assign last_sec  = min_q == 4'd0 && tens_q == 4'd0 && ones_q == 4'd1;

    // start and load are dropped in RUN, so counting falls through to the last branch.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        min_d   = min_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (clear) begin
            state_d = IDLE;
            div_d   = '0;
            min_d   = 4'd0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
        end else if (stop_req) begin
            state_d = in_run ? PAUSE : state_q;
        end else if (start_req && !in_run) begin
            if (nonzero) begin
                state_d = RUN;
                div_d   = state_q == PAUSE ? div_q : '0;
            end
        end else if (load && !in_run) begin
            if (load_ok) begin
                min_d   = load_min;
                tens_d  = load_sec_tens;
                ones_d  = load_sec_ones;
                div_d   = '0;
                state_d = state_q == DONE ? IDLE : state_q;
            end else begin
                err_d = 1'b1;
            end
        end else if (in_run) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                if (ones_q != 4'd0) begin
                    ones_d = ones_q - 4'd1;
                end else if (tens_q != 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else if (min_q != 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = 4'd5;
                    min_d  = min_q - 4'd1;
                end
                if (last_sec) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
        end
        running_d = state_d == RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            min_q     <= 4'd0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            min_q     <= min_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            running_q <= running_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign min      = min_q;
    assign sec_tens = tens_q;
    assign sec_ones = ones_q;
    assign running  = running_q;
    assign done     = done_q;
    assign load_err = err_q;
endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
- Microwave cook timer: holds an M:SS time as three BCD digits (minutes 0-9, seconds tens 0-5, seconds ones 0-9).
- Counts the time down once per second while running.
- Sits directly upstream of the 7-segment decoder; its min/sec_tens/sec_ones outputs drive the decoder inputs of the same names without any glue logic.
- Load, start, stop and clear requests come from the control FSM; done goes back to it.

Parameters:
- TICKS_PER_SEC, 100, clk cycles per one-second decrement, legal range >= 2. Benches use 4.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- load  input  1  single-cycle request to load the three load_* digits
- load_min  input  4  BCD minutes to load, legal 0-9
- load_sec_tens  input  4  BCD seconds tens to load, legal 0-5
- load_sec_ones  input  4  BCD seconds ones to load, legal 0-9
- start  input  1  begin or resume the countdown
- stop  input  1  pause the countdown
- clear  input  1  zero the time and return to IDLE
- min  output  4  current minutes digit, registered
- sec_tens  output  4  current seconds-tens digit, registered
- sec_ones  output  4  current seconds-ones digit, registered
- running  output  1  high while in RUN
- done  output  1  single-cycle pulse when the time reaches 0:00
- load_err  output  1  single-cycle pulse when a load is rejected

Behaviour:
- Reset: one clk with rst=1 gives state=IDLE, all digits 0, divider=0, running=0, done=0, load_err=0. Reset has priority over every other input, including mid-RUN.
- States:
  - IDLE: time is settable; no counting.
  - RUN: counting down.
  - PAUSE: time and divider frozen.
  - DONE: time reads 0:00, waiting for a new load or clear.
- Request priority per cycle: clear > stop > start > load. Only the highest-priority asserted request acts; the others in that cycle are dropped.
- clear (any state): next cycle gives digits=0, divider=0, state=IDLE.
- stop: in RUN, go to PAUSE; divider holds its value. Ignored in other states.
- start:
  - From IDLE or DONE with a nonzero time: divider=0, go to RUN.
  - From PAUSE with a nonzero time: go to RUN with the divider resumed as held.
  - If the time is 0:00, or the state is already RUN, start is ignored.
- load: accepted in IDLE, PAUSE and DONE; ignored with no error in RUN.
  - Valid digits (load_min<=9, load_sec_tens<=5, load_sec_ones<=9): digits update the next cycle, divider=0, and DONE goes to IDLE.
  - Invalid digits: digits unchanged and load_err=1 for exactly one cycle.
- Divider (RUN only):
  - Counts 0..TICKS_PER_SEC-1. A tick occurs in the cycle where divider==TICKS_PER_SEC-1; the divider then wraps to 0.
  - The first decrement therefore lands TICKS_PER_SEC cycles after start from IDLE.
- Decrement on tick, applied in this order:
  - sec_ones>0: sec_ones-1.
  - Else sec_tens>0: sec_ones=9, sec_tens-1.
  - Else min>0: sec_ones=9, sec_tens=5, min-1.
  - Digits never leave their BCD ranges; no binary wrap is permitted.
- Terminal condition: when a tick moves the time from 0:01 to 0:00:
  - In that same update: state=DONE, running=0.
  - done=1 for exactly the one cycle in which the time first reads 0:00.
  - No further ticks are counted.
- stop and a tick in the same cycle: stop wins; the decrement is not applied.
- running is a registered decode of the state; it goes high the cycle after start is accepted.

Optional Feature:
- Macro: DOOR_INTERLOCK_EN.
- Defined: adds input door_open (1 bit).
  - door_open=1 in RUN forces PAUSE on the next cycle; priority equals stop.
  - start is ignored while door_open=1.
  - load and clear are unaffected.
- Undefined: the port does not exist, and start/stop behaviour is exactly as specified above.

Test Plan (TICKS_PER_SEC=4):
- Reset, then load 1,0,2 and start: display 1:02 -> 1:01 -> 1:00 -> 0:59, one step every 4 clk, with the first step 4 clk after the start cycle. running=1 throughout.
- Load 0,0,2 and start: after 8 clk display is 0:00; done=1 for exactly 1 cycle; running=0; further clk leave 0:00 with done=0.
- Load 0,1,5, start, then stop after 6 clk: display holds 0:14 and running=0 for 10 clk. Start again: 0:13 appears 2 clk later, because the divider resumed from its held value.
- Load 15,10,13 in IDLE: load_err=1 for 1 cycle and the digits stay at their previous value. Load 9,6,0: rejected, because sec_tens exceeds 5.
- Start at 0:00: ignored, running stays 0. clear, stop and start asserted together during RUN: next cycle is IDLE at 0:00.
- rst asserted during RUN at 0:37: next cycle gives 0:00, IDLE, and all outputs at 0. With DOOR_INTERLOCK_EN defined, door_open=1 during RUN gives PAUSE the next cycle, and start is ignored until door_open=0.
